// File: rtl/rx_frame_ctrl_if.sv
// Signal bundle between the serial receiver frame controller, its sampling
// stage and the consumer of received bytes.
interface rx_frame_ctrl_if;
    logic       RX_IN;
    logic [4:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       data_samp_en;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    // Environment side: drives the line, configuration and the voted bit.
    modport master (
        output RX_IN,
        output prescale,
        output PAR_EN,
        output PAR_TYP,
        output sampled_bit,
        input  data_samp_en,
        input  edge_cnt,
        input  P_DATA,
        input  data_valid,
        input  par_err,
        input  stp_err
    );

    // Frame controller side.
    modport slave (
        input  RX_IN,
        input  prescale,
        input  PAR_EN,
        input  PAR_TYP,
        input  sampled_bit,
        output data_samp_en,
        output edge_cnt,
        output P_DATA,
        output data_valid,
        output par_err,
        output stp_err
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// UART-style receive frame controller. Walks a frame bit by bit using an
// oversampling edge counter, consumes the voted bit from the sampling stage
// once per bit, assembles the byte and reports good data or framing/parity
// errors as single-cycle registered strobes.
module rx_frame_ctrl (
    input  logic           clk,
    input  logic           rst,
    rx_frame_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    // Frame bits counted on each edge-counter wrap: start is bit 0, data 1..8.
    localparam logic [3:0] LastDataBit = 4'd8;

    state_e      state_q, state_d;
    logic [4:0]  edge_cnt_q, edge_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [4:0]  presc_q, presc_d;
    logic        par_en_q, par_en_d;
    logic        par_typ_q, par_typ_d;
    logic        par_pend_q, par_pend_d;
    logic [7:0]  p_data_q, p_data_d;
    logic        data_valid_q, data_valid_d;
    logic        par_err_q, par_err_d;
    logic        stp_err_q, stp_err_d;

    logic        at_decision;
    logic        exp_parity;

    // Last edge of the current bit period; the voted bit is only trusted here.
    assign at_decision = (edge_cnt_q == (presc_q - 5'd1));

    // Even parity is the XOR of the data bits, odd parity its inverse.
    assign exp_parity = (^shift_q) ^ par_typ_q;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            edge_cnt_q   <= 5'd0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            presc_q      <= 5'd0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_pend_q   <= 1'b0;
            p_data_q     <= 8'h00;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_pend_q   <= par_pend_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    // Next-state, counters, byte assembly and strobe generation.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_pend_d   = par_pend_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q == StIdle) begin
            edge_cnt_d = 5'd0;
            bit_cnt_d  = 4'd0;
        end else if (at_decision) begin
            edge_cnt_d = 5'd0;
            bit_cnt_d  = bit_cnt_q + 4'd1;
        end else begin
            edge_cnt_d = edge_cnt_q + 5'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!bus.RX_IN) begin
                    // Configuration is frozen for the whole frame.
                    state_d    = StStart;
                    presc_d    = bus.prescale;
                    par_en_d   = bus.PAR_EN;
                    par_typ_d  = bus.PAR_TYP;
                    par_pend_d = 1'b0;
                end
            end

            StStart: begin
                if (at_decision) begin
                    // A high start bit was a line glitch: drop it silently.
                    state_d = bus.sampled_bit ? StIdle : StData;
                end
            end

            StData: begin
                if (at_decision) begin
                    shift_d = {bus.sampled_bit, shift_q[7:1]};
                    if (bit_cnt_q == LastDataBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end

            StParity: begin
                if (at_decision) begin
                    // shift_q holds the complete byte by now.
                    par_pend_d = (bus.sampled_bit != exp_parity);
                    state_d    = StStop;
                end
            end

            StStop: begin
                if (at_decision) begin
                    state_d = StIdle;
                    if (bus.sampled_bit && !par_pend_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end else begin
                        stp_err_d = !bus.sampled_bit;
                        par_err_d = par_pend_q;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.data_samp_en = (state_q != StIdle);
    assign bus.edge_cnt     = edge_cnt_q;
    assign bus.P_DATA       = p_data_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.par_err      = par_err_q;
    assign bus.stp_err      = stp_err_q;

endmodule
